cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine for the single-issue RV32I core.
- Receives per-instruction enables from the combinational decoder and gates them into single-cycle strobes.
- Runs valid/ready handshakes with instruction and data memory, counts retired instructions and enforces a memory-wait watchdog.
- Handles illegal opcodes, watchdog expiry and external debug halt/resume.

Parameters:
TIMEOUT_CYCLES, 255, maximum wait cycles on a memory handshake before a fault (1..65535).
COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
i_Clock  in  1  core clock
i_Reset_N  in  1  asynchronous active-low reset
i_Op_Code  in  7  opcode of the latched instruction, valid from DECODE onward
i_Reg_Write_Enable  in  1  decoder register-write enable
i_Mem_Write_Enable  in  1  decoder memory-write enable (store)
i_Instr_Valid  in  1  instruction memory returns data this cycle
i_Dmem_Ready  in  1  data memory has accepted or completed the access
i_Halt_Request  in  1  debug halt request, level
i_Resume  in  1  debug resume pulse
o_Instr_Req  out  1  instruction fetch request
o_Instr_Latch  out  1  one-cycle strobe to load the instruction register
o_Dmem_Req  out  1  data memory request
o_Dmem_Write  out  1  qualifies o_Dmem_Req as a write
o_Reg_Write  out  1  one-cycle register file write strobe
o_Pc_Write  out  1  one-cycle PC update strobe
o_Halted  out  1  sequencer is in HALT
o_Fault  out  2  0 none, 1 illegal opcode, 2 fetch timeout, 3 dmem timeout
o_Retired_Count  out  COUNT_WIDTH  instructions retired since reset

Behaviour:
- Reset (async, i_Reset_N=0):
  - State goes to FETCH, all outputs 0, wait counter 0, o_Retired_Count 0.
  - Deassertion is synchronised internally with a 2-flop release. The first o_Instr_Req is high on the 2nd clock edge after release.
- FETCH:
  - o_Instr_Req=1.
  - On i_Instr_Valid: pulse o_Instr_Latch the same cycle and go to DECODE.
- DECODE (1 cycle):
  - Legal opcodes are 0110011, 0110111, 0010111, 1101111, 0010011, 1100111, 0000011, 0100011, 1100011.
  - Any other opcode: go to HALT with o_Fault=1.
  - Otherwise go to EXECUTE.
- EXECUTE (1 cycle):
  - Opcodes 0000011 (load) and 0100011 (store) go to MEMORY.
  - All others go to WRITEBACK.
- MEMORY:
  - o_Dmem_Req=1 and o_Dmem_Write=i_Mem_Write_Enable, both held until i_Dmem_Ready.
  - On i_Dmem_Ready go to WRITEBACK.
- WRITEBACK (1 cycle):
  - o_Reg_Write=i_Reg_Write_Enable and o_Pc_Write=1.
  - o_Retired_Count increments by 1, wrapping modulo 2^COUNT_WIDTH.
  - Next state is HALT if i_Halt_Request=1 (o_Fault stays 0), else FETCH.
- HALT:
  - Strobes and requests are 0 and o_Halted=1.
  - i_Resume with o_Fault=0: go to FETCH.
  - i_Resume with o_Fault!=0: ignored, because faults are sticky until reset.
- Latency:
  - Non-memory instruction with zero-wait fetch: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - Load/store with zero-wait memories: 5 cycles.
  - Each memory wait cycle adds 1.
- Watchdog:
  - Counter clears on entry to FETCH and on entry to MEMORY.
  - Increments each cycle the handshake is outstanding.
  - If the count reaches TIMEOUT_CYCLES with no valid/ready: drop the request next cycle, go to HALT, o_Fault=2 (FETCH) or 3 (MEMORY).
  - Valid/ready arriving on the same cycle the count hits TIMEOUT_CYCLES wins: the handshake completes and there is no fault.
- Halt rules:
  - i_Halt_Request is sampled only in WRITEBACK, so an in-flight instruction always retires before halting.
  - i_Resume outside HALT is ignored.
  - i_Resume and i_Halt_Request both high in HALT: resume to FETCH, then halt again at the next WRITEBACK.
- Reset mid-operation: immediate abort. No strobe completes, and a pending memory request drops asynchronously.
- o_Dmem_Write is 0 whenever o_Dmem_Req is 0.
- o_Reg_Write and o_Pc_Write are never high outside WRITEBACK.

Test Plan:
- Reset, then ADDI (0010011), i_Instr_Valid held 1, i_Reg_Write_Enable=1: o_Reg_Write and o_Pc_Write pulse on the 4th cycle after first o_Instr_Req; o_Retired_Count=1.
- LW (0000011), i_Dmem_Ready delayed 3 cycles: o_Dmem_Req high 4 cycles, o_Dmem_Write=0, retire at cycle 8; SW the same path with o_Dmem_Write=1, o_Reg_Write=0.
- Opcode 1110011: o_Halted=1 and o_Fault=1 one cycle after DECODE; i_Resume ignored; reset clears the fault.
- TIMEOUT_CYCLES=4, i_Instr_Valid held 0: HALT with o_Fault=2 after 4 wait cycles. Repeat with valid arriving on the 4th wait cycle: normal DECODE, o_Fault=0.
- i_Halt_Request raised during MEMORY of a store: store completes, retire count increments, HALT with o_Fault=0; i_Resume pulse gives FETCH next cycle.
- Counter wrap with COUNT_WIDTH=4: 17 retired instructions give o_Retired_Count=1. Async reset asserted during a MEMORY wait: o_Dmem_Req drops without a clock edge.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// Handshake and strobe bundle between the RV32I sequencer and its environment.
// master = sequencer side, slave = decoder/memories/debug side.
interface cpu_sequencer_if #(
  parameter int COUNT_WIDTH = 32
);
  logic [6:0]             i_Op_Code;
  logic                   i_Reg_Write_Enable;
  logic                   i_Mem_Write_Enable;
  logic                   i_Instr_Valid;
  logic                   i_Dmem_Ready;
  logic                   i_Halt_Request;
  logic                   i_Resume;
  logic                   o_Instr_Req;
  logic                   o_Instr_Latch;
  logic                   o_Dmem_Req;
  logic                   o_Dmem_Write;
  logic                   o_Reg_Write;
  logic                   o_Pc_Write;
  logic                   o_Halted;
  logic [1:0]             o_Fault;
  logic [COUNT_WIDTH-1:0] o_Retired_Count;

  modport master (
    input  i_Op_Code, i_Reg_Write_Enable, i_Mem_Write_Enable, i_Instr_Valid,
           i_Dmem_Ready, i_Halt_Request, i_Resume,
    output o_Instr_Req, o_Instr_Latch, o_Dmem_Req, o_Dmem_Write, o_Reg_Write,
           o_Pc_Write, o_Halted, o_Fault, o_Retired_Count
  );

  modport slave (
    output i_Op_Code, i_Reg_Write_Enable, i_Mem_Write_Enable, i_Instr_Valid,
           i_Dmem_Ready, i_Halt_Request, i_Resume,
    input  o_Instr_Req, o_Instr_Latch, o_Dmem_Req, o_Dmem_Write, o_Reg_Write,
           o_Pc_Write, o_Halted, o_Fault, o_Retired_Count
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the RV32I core.
// Gates decoder enables into single-cycle strobes, runs the imem/dmem handshakes
// under a watchdog, counts retired instructions and handles debug halt/resume.
module cpu_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic            i_Clock,
  input  logic            i_Reset_N,
  cpu_sequencer_if.master bus
);

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] FLT_NONE    = 2'd0;
  localparam logic [1:0] FLT_ILLEGAL = 2'd1;
  localparam logic [1:0] FLT_FETCH   = 2'd2;
  localparam logic [1:0] FLT_DMEM    = 2'd3;

  // Watchdog fires when the current wait cycle is the TIMEOUT_CYCLES-th one.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_HALT
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             fault_q, fault_d;
  logic [15:0]            wdog_q, wdog_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;
  logic [1:0]             rst_sync_q;
  logic                   rst_int_n;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_OP, OP_LUI, OP_AUIPC, OP_JAL, OP_OPIMM,
      OP_JALR, OP_LOAD, OP_STORE, OP_BRANCH: is_legal = 1'b1;
      default:                               is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    is_mem = (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Reset synchroniser: asserts immediately, releases two edges after i_Reset_N rises.
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  // Next-state, watchdog, fault and retire-count computation.
  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    wdog_d    = '0;
    retired_d = retired_q;
    case (state_q)
      S_FETCH: begin
        if (bus.i_Instr_Valid) begin
          state_d = S_DECODE;
        end else if (wdog_q == TMO_LAST) begin
          state_d = S_HALT;
          fault_d = FLT_FETCH;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      S_DECODE: begin
        if (is_legal(bus.i_Op_Code)) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_HALT;
          fault_d = FLT_ILLEGAL;
        end
      end
      S_EXECUTE: begin
        state_d = is_mem(bus.i_Op_Code) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        if (bus.i_Dmem_Ready) begin
          state_d = S_WRITEBACK;
        end else if (wdog_q == TMO_LAST) begin
          state_d = S_HALT;
          fault_d = FLT_DMEM;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      S_WRITEBACK: begin
        // Halt is only honoured here so the in-flight instruction always retires.
        retired_d = retired_q + COUNT_WIDTH'(1);
        state_d   = bus.i_Halt_Request ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        // Faults are sticky: only reset leaves a faulted HALT.
        if (bus.i_Resume && (fault_q == FLT_NONE)) state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Sequencer state registers, held in reset until the synchronised release.
  always_ff @(posedge i_Clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= S_FETCH;
      fault_q   <= FLT_NONE;
      wdog_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      wdog_q    <= wdog_d;
      retired_q <= retired_d;
    end
  end

  // Outputs decode the registered state; qualifying with rst_int_n keeps them low
  // through reset and drops a pending request as soon as reset asserts.
  assign bus.o_Instr_Req     = rst_int_n && (state_q == S_FETCH);
  assign bus.o_Instr_Latch   = rst_int_n && (state_q == S_FETCH) && bus.i_Instr_Valid;
  assign bus.o_Dmem_Req      = rst_int_n && (state_q == S_MEMORY);
  assign bus.o_Dmem_Write    = rst_int_n && (state_q == S_MEMORY) && bus.i_Mem_Write_Enable;
  assign bus.o_Reg_Write     = rst_int_n && (state_q == S_WRITEBACK) && bus.i_Reg_Write_Enable;
  assign bus.o_Pc_Write      = rst_int_n && (state_q == S_WRITEBACK);
  assign bus.o_Halted        = rst_int_n && (state_q == S_HALT);
  assign bus.o_Fault         = fault_q;
  assign bus.o_Retired_Count = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed table, hand-written corner sequences and
// randomized instructions checked against a per-instruction phase model.
module tb_cpu_sequencer;
  localparam int T  = 4;
  localparam int CW = 4;

  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] ILL  = 7'b1110011;

  // expected bits: {req, latch, dreq, dwr, rw, pcw, halted, fault[1:0]}
  localparam logic [8:0] E_REQ = 9'b1_0000_0000;
  localparam logic [8:0] E_LAT = 9'b0_1000_0000;
  localparam logic [8:0] E_DRQ = 9'b0_0100_0000;
  localparam logic [8:0] E_DWR = 9'b0_0010_0000;
  localparam logic [8:0] E_RW  = 9'b0_0001_0000;
  localparam logic [8:0] E_PCW = 9'b0_0000_1000;
  localparam logic [8:0] E_HLT = 9'b0_0000_0100;

  typedef struct packed {
    logic          valid;
    logic          rdy;
    logic [6:0]    op;
    logic          rwe;
    logic          mwe;
    logic          halt;
    logic          res;
    logic [8:0]    e;
    logic [CW-1:0] c;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.COUNT_WIDTH(CW)) bus();
  cpu_sequencer #(.TIMEOUT_CYCLES(T), .COUNT_WIDTH(CW)) dut (
    .i_Clock(clk), .i_Reset_N(rst_n), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  cyc_t q[$];
  cyc_t tbl[$];
  logic [CW-1:0] cnt_m;
  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0110111, 7'b0010111, 7'b1101111,
                                7'b0010011, 7'b1100111, 7'b0000011, 7'b0100011,
                                7'b1100011};

  function automatic logic [8:0] obs();
    return {bus.o_Instr_Req, bus.o_Instr_Latch, bus.o_Dmem_Req, bus.o_Dmem_Write,
            bus.o_Reg_Write, bus.o_Pc_Write, bus.o_Halted, bus.o_Fault};
  endfunction

  function automatic cyc_t mk(input logic v, r, input logic [6:0] o,
                              input logic rw, mw, h, rs,
                              input logic [8:0] e, input logic [CW-1:0] c);
    cyc_t x;
    x.valid = v; x.rdy = r; x.op = o; x.rwe = rw; x.mwe = mw;
    x.halt = h; x.res = rs; x.e = e; x.c = c;
    return x;
  endfunction

  function automatic logic rb(input bit en);
    return en ? 1'($urandom) : 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [8:0] e, input logic [CW-1:0] c);
    vectors++;
    if (obs() !== e || bus.o_Retired_Count !== c) begin
      miscompares++;
      $display("FAIL %s @%0t: got outs=%b cnt=%0d, want outs=%b cnt=%0d",
               nm, $time, obs(), bus.o_Retired_Count, e, c);
    end
  endtask

  task automatic drive(input cyc_t x);
    bus.i_Instr_Valid      = x.valid;
    bus.i_Dmem_Ready       = x.rdy;
    bus.i_Op_Code          = x.op;
    bus.i_Reg_Write_Enable = x.rwe;
    bus.i_Mem_Write_Enable = x.mwe;
    bus.i_Halt_Request     = x.halt;
    bus.i_Resume           = x.res;
  endtask

  // Starts at posedge+1; each record is driven, checked at negedge, then clocked.
  task automatic run_q(input string nm);
    foreach (q[i]) begin
      drive(q[i]);
      @(negedge clk);
      chk(nm, q[i].e, q[i].c);
      @(posedge clk); #1;
    end
    q.delete();
  endtask

  // Ends at posedge+1 of the first cycle in which o_Instr_Req must be high.
  task automatic do_reset();
    drive(mk(0, 0, 7'd0, 0, 0, 0, 0, 9'd0, '0));
    rst_n = 1'b0;
    #1 chk("reset_async", 9'd0, '0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_hold", 9'd0, '0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk) chk("reset_release_edge1", 9'd0, '0);
    @(posedge clk); #1;
    cnt_m = '0;
  endtask

  // Phase-level model of one instruction: appends the expected cycle trace to q.
  task automatic gen_instr(input int wf, input logic [6:0] op, input logic rwe, mwe,
                           input int wm, input logic hreq, input bit nz,
                           output bit faulted);
    logic [1:0] f;
    bit legal, ismem;
    legal = op inside {7'b0110011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0010011,
                       7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011};
    ismem = (op == LW) || (op == SW);
    f = 2'd0;
    for (int k = 0; k < ((wf >= T) ? T : wf); k++)
      q.push_back(mk(0, rb(nz), nz ? 7'($urandom) : op, rb(nz), rb(nz), rb(nz), rb(nz),
                     E_REQ, cnt_m));
    if (wf >= T) begin
      f = 2'd2;
    end else begin
      q.push_back(mk(1, rb(nz), op, rb(nz), rb(nz), rb(nz), rb(nz), E_REQ | E_LAT, cnt_m));
      q.push_back(mk(rb(nz), rb(nz), op, rb(nz), rb(nz), rb(nz), rb(nz), 9'd0, cnt_m));
      if (!legal) begin
        f = 2'd1;
      end else begin
        q.push_back(mk(rb(nz), rb(nz), op, rb(nz), rb(nz), rb(nz), rb(nz), 9'd0, cnt_m));
        if (ismem) begin
          for (int k = 0; k < ((wm >= T) ? T : wm); k++)
            q.push_back(mk(rb(nz), 0, op, rb(nz), mwe, hreq | rb(nz), rb(nz),
                           E_DRQ | (mwe ? E_DWR : 9'd0), cnt_m));
          if (wm >= T) f = 2'd3;
          else q.push_back(mk(rb(nz), 1, op, rb(nz), mwe, hreq | rb(nz), rb(nz),
                              E_DRQ | (mwe ? E_DWR : 9'd0), cnt_m));
        end
        if (f == 2'd0) begin
          q.push_back(mk(rb(nz), rb(nz), op, rwe, rb(nz), hreq, rb(nz),
                         E_PCW | (rwe ? E_RW : 9'd0), cnt_m));
          cnt_m++;
          if (hreq) begin
            q.push_back(mk(rb(nz), rb(nz), op, rb(nz), rb(nz), rb(nz), 0, E_HLT, cnt_m));
            q.push_back(mk(rb(nz), rb(nz), op, rb(nz), rb(nz), rb(nz), 1, E_HLT, cnt_m));
          end
        end
      end
    end
    faulted = (f != 2'd0);
    if (faulted)
      for (int k = 0; k < 2; k++)
        q.push_back(mk(0, 0, op, 0, 0, 0, 1'(k == 0), E_HLT | {7'd0, f}, cnt_m));
  endtask

  initial begin
    bit fb;
    do_reset();

    // Directed table: ADDI, LW with 3 waits, SW with 3 waits, illegal opcode.
    tbl.push_back(mk(1, 0, ADDI, 1, 0, 0, 0, E_REQ | E_LAT, 4'd0));
    tbl.push_back(mk(0, 0, ADDI, 1, 0, 0, 0, 9'd0, 4'd0));
    tbl.push_back(mk(0, 0, ADDI, 1, 0, 0, 0, 9'd0, 4'd0));
    tbl.push_back(mk(0, 0, ADDI, 1, 0, 0, 0, E_RW | E_PCW, 4'd0));
    tbl.push_back(mk(1, 0, LW, 1, 0, 0, 0, E_REQ | E_LAT, 4'd1));
    tbl.push_back(mk(0, 0, LW, 1, 0, 0, 0, 9'd0, 4'd1));
    tbl.push_back(mk(0, 0, LW, 1, 0, 0, 0, 9'd0, 4'd1));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, LW, 1, 0, 0, 0, E_DRQ, 4'd1));
    tbl.push_back(mk(0, 1, LW, 1, 0, 0, 0, E_DRQ, 4'd1));
    tbl.push_back(mk(0, 0, LW, 1, 0, 0, 0, E_RW | E_PCW, 4'd1));
    tbl.push_back(mk(1, 0, SW, 0, 1, 0, 0, E_REQ | E_LAT, 4'd2));
    tbl.push_back(mk(0, 0, SW, 0, 1, 0, 0, 9'd0, 4'd2));
    tbl.push_back(mk(0, 0, SW, 0, 1, 0, 0, 9'd0, 4'd2));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, SW, 0, 1, 0, 0, E_DRQ | E_DWR, 4'd2));
    tbl.push_back(mk(0, 1, SW, 0, 1, 0, 0, E_DRQ | E_DWR, 4'd2));
    tbl.push_back(mk(0, 0, SW, 0, 1, 0, 0, E_PCW, 4'd2));
    tbl.push_back(mk(1, 0, ILL, 0, 0, 0, 0, E_REQ | E_LAT, 4'd3));
    tbl.push_back(mk(0, 0, ILL, 0, 0, 0, 0, 9'd0, 4'd3));
    tbl.push_back(mk(0, 0, ILL, 0, 0, 0, 1, E_HLT | 9'd1, 4'd3));
    tbl.push_back(mk(0, 0, ILL, 0, 0, 0, 0, E_HLT | 9'd1, 4'd3));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("table[%0d]", i), tbl[i].e, tbl[i].c);
      @(posedge clk); #1;
    end
    do_reset();

    // Fetch watchdog expiry, then valid arriving on the last allowed wait cycle.
    gen_instr(T, ADDI, 1, 0, 0, 0, 0, fb); run_q("fetch_timeout");
    do_reset();
    gen_instr(T - 1, ADDI, 1, 0, 0, 0, 0, fb); run_q("fetch_valid_at_limit");

    // Halt raised during a store's MEMORY phase, resume, then a normal instruction.
    gen_instr(0, SW, 0, 1, 2, 1, 0, fb); run_q("halt_in_store");
    gen_instr(0, ADDI, 1, 0, 0, 0, 0, fb); run_q("after_resume");

    // Data-memory watchdog expiry.
    gen_instr(0, LW, 1, 0, T, 0, 0, fb); run_q("dmem_timeout");
    do_reset();

    // Counter wrap: 17 retirements on a 4-bit counter.
    for (int k = 0; k < 17; k++) gen_instr(0, ADDI, 1, 0, 0, 0, 0, fb);
    run_q("wrap_seq");
    drive(mk(0, 0, LW, 0, 0, 0, 0, 9'd0, '0));
    @(negedge clk) chk("wrap_count", E_REQ, 4'd1);

    // Async reset in the middle of a MEMORY wait.
    @(posedge clk); #1;
    bus.i_Instr_Valid = 1'b1;
    @(posedge clk); #1;
    bus.i_Instr_Valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk) chk("mem_wait_before_reset", E_DRQ, 4'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_drops_dreq", 9'd0, 4'd0);
    do_reset();

    // Randomized instructions with noise on inputs that must be ignored.
    for (int n = 0; n < 150; n++) begin
      int wf, wm;
      logic [6:0] op;
      wf = ($urandom % 8 == 0) ? T + int'($urandom % 2) : int'($urandom % T);
      wm = ($urandom % 8 == 0) ? T : int'($urandom % T);
      op = ($urandom % 6 == 0) ? 7'($urandom) : legal_ops[$urandom % 9];
      gen_instr(wf, op, 1'($urandom), 1'($urandom), wm, ($urandom % 5 == 0), 1, fb);
      run_q($sformatf("rand[%0d]", n));
      if (fb) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
